// File: rtl/pipe_elastic_buf.sv
// Elastic valid/ready pipeline register with DEPTH-entry circular storage
// and synchronous flush; optional zero-latency bypass via PIPE_BYPASS_EN.
//
// Ports:
//   clk, rstn        clock (rising edge), async active-low reset
//   flush            synchronous drop of all stored entries
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   count            number of stored entries, 0..DEPTH
// Build option: PIPE_BYPASS_EN enables the empty-buffer pass-through path.

module pipe_elastic_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic empty;
  logic push;
  logic thru;
  logic wr_en;
  logic pop;

  // Pointers wrap on an explicit compare so DEPTH need not be 2^n.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (cnt == '0);
  assign in_ready = (cnt != CNT_W'(DEPTH));
  assign count    = cnt;
  assign push     = in_valid & in_ready;
  // Stored entries leave only when something is actually held.
  assign pop      = out_ready & ~empty;

`ifdef PIPE_BYPASS_EN
  logic byp;
  assign byp       = empty & ~flush;
  assign out_valid = empty ? (in_valid & ~flush) : 1'b1;
  assign out_data  = byp ? in_data : mem[rd_ptr];
  // Item taken straight through is never written.
  assign thru      = byp & in_valid & out_ready;
`else
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];
  assign thru      = 1'b0;
`endif

  assign wr_en = push & ~thru;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (1'b1)
        flush: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end
        default: begin
          if (wr_en) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= nxt(wr_ptr);
          end
          if (pop) begin
            rd_ptr <= nxt(rd_ptr);
          end
          unique case (1'b1)
            wr_en & ~pop: cnt <= cnt + CNT_W'(1);
            pop & ~wr_en: cnt <= cnt - CNT_W'(1);
            default:      cnt <= cnt;
          endcase
        end
      endcase
    end
  end

endmodule
